// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the byte-RAM word controller.
// Holds the FSM state encoding and the derivation of the word-index width.
package ram_ctrl_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEPTH_DEFAULT  = 32;

  function automatic int widx_w_of(input int depth);
    return $clog2(depth / BYTES_PER_WORD);
  endfunction

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_XFER,
    ST_FLUSH,
    ST_ACK
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
// Port 0 wins the first tie after reset because the pointer resets to 1.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    if (grant_en) begin
      if (req == 2'b11) begin
        grant = last_q ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
      if (|req) begin
        last_d = grant[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one byte-wide RAM between fetch (port 0) and load/store (port 1),
// moving each 32-bit word as four little-endian byte accesses.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int WIDX_W = widx_w_of(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [WIDX_W-1:0] widx0,
  input  logic [WIDX_W-1:0] widx1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              mem_rst,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [23:0]         asm_q, asm_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                busy_q, busy_d;
  logic                mem_rst_q, mem_rst_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [WIDX_W+1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;

  logic [1:0]          grant;
  logic                grant_en;
  logic                sel_we;
  logic [WIDX_W-1:0]   sel_widx;
  logic [31:0]         sel_wdata;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({req1, req0}),
    .grant_en (grant_en),
    .grant    (grant)
  );

  assign sel_we    = grant[1] ? we1    : we0;
  assign sel_widx  = grant[1] ? widx1  : widx0;
  assign sel_wdata = grant[1] ? wdata1 : wdata0;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    port_d      = port_q;
    we_d        = we_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    mem_rst_d   = 1'b0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_en    = 1'b0;

    case (state_q)
      ST_CLEAR: state_d = ST_IDLE;
      ST_IDLE: begin
        grant_en = 1'b1;
        if (|grant) begin
          port_d      = grant[1];
          we_d        = sel_we;
          widx_d      = sel_widx;
          wdata_d     = sel_wdata;
          byte_cnt_d  = 2'd0;
          state_d     = ST_XFER;
          mem_addr_d  = {sel_widx, 2'd0};
          mem_wr_d    = sel_we;
          mem_rd_d    = !sel_we;
          mem_wdata_d = sel_wdata[7:0];
        end
      end
      ST_XFER: begin
        // RAM read data lags its address by one cycle, so byte n-1 lands now.
        if (!we_q) begin
          case (byte_cnt_q)
            2'd1:    asm_d[7:0]   = mem_rdata;
            2'd2:    asm_d[15:8]  = mem_rdata;
            2'd3:    asm_d[23:16] = mem_rdata;
            default: asm_d        = asm_q;
          endcase
        end
        if (byte_cnt_q == 2'd3) begin
          state_d = ST_FLUSH;
        end else begin
          byte_cnt_d  = byte_cnt_q + 2'd1;
          mem_addr_d  = {widx_q, byte_cnt_d};
          mem_wr_d    = we_q;
          mem_rd_d    = !we_q;
          mem_wdata_d = wdata_q[{byte_cnt_d, 3'b000} +: 8];
        end
      end
      ST_FLUSH: begin
        state_d = ST_ACK;
        ack0_d  = !port_q;
        ack1_d  = port_q;
        if (!we_q) begin
          rdata_d = {mem_rdata, asm_q};
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      byte_cnt_q  <= 2'd0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      widx_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b1;
      mem_rst_q   <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      port_q      <= port_d;
      we_q        <= we_d;
      widx_q      <= widx_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
      mem_rst_q   <= mem_rst_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_rst   = mem_rst_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = 32'(mem_addr_q);
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: byte-RAM model, transaction-level reference model,
// strobe scoreboard, directed scenarios and a randomized two-port phase.
module tb_ram_arbiter;

  localparam int DEPTH  = 32;
  localparam int WIDX_W = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req0 = 1'b0, req1 = 1'b0;
  logic              we0 = 1'b0, we1 = 1'b0;
  logic [WIDX_W-1:0] widx0 = '0, widx1 = '0;
  logic [31:0]       wdata0 = '0, wdata1 = '0;
  logic              ack0, ack1, busy, mem_rst, mem_rd, mem_wr;
  logic [31:0]       rdata, mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;

  ram_arbiter #(.DEPTH(DEPTH), .WIDX_W(WIDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .widx0(widx0), .widx1(widx1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_rst(mem_rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // byte RAM with synchronous clear and registered read
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'h00;
    end else begin
      if (mem_wr) ram[mem_addr[4:0]] <= mem_wdata;
      if (mem_rd) mem_rdata <= ram[mem_addr[4:0]];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // reference model: transactions serialize, one arbitration per 7 edges
  logic [7:0]  m_mem [DEPTH];
  logic [40:0] exp_q [$];
  logic [39:0] wr_log [$];
  int          edge_cnt = 0, next_arb = 0, ack_edge = -10, rst_edge = -10;
  int          m_last = 1, txn_port = 0;
  bit          txn_act = 0, txn_we = 0, started = 0;
  logic [31:0] txn_val = '0, exp_rdata = '0;

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      exp_q.delete();
      txn_act   = 0;
      m_last    = 1;
      rst_edge  = edge_cnt;
      next_arb  = edge_cnt + 2;
      exp_rdata = '0;
      started   = 1;
    end else begin
      if (txn_act && edge_cnt == ack_edge && !txn_we) exp_rdata = txn_val;
      if (edge_cnt == next_arb) begin
        if (req0 || req1) begin
          int p, a;
          logic w;
          logic [31:0] d;
          p = (req0 && req1) ? ((m_last == 1) ? 0 : 1) : (req1 ? 1 : 0);
          m_last = p;
          w = p ? we1 : we0;
          a = 4 * int'(p ? widx1 : widx0);
          d = p ? wdata1 : wdata0;
          for (int b = 0; b < 4; b++) begin
            logic [7:0] by;
            by = 8'(d >> (8 * b));
            if (w) m_mem[a + b] = by;
            exp_q.push_back({w, 32'(a + b), w ? by : 8'h00});
          end
          txn_val  = {m_mem[a + 3], m_mem[a + 2], m_mem[a + 1], m_mem[a]};
          txn_act  = 1;
          txn_we   = w;
          txn_port = p;
          ack_edge = edge_cnt + 5;
          next_arb = edge_cnt + 7;
        end else begin
          next_arb = edge_cnt + 1;
        end
      end
    end
  end

  // scoreboard: outputs sampled on the falling edge
  always @(negedge clk) begin
    if (started) begin
      check("mem_rst", mem_rst, !rst_n || edge_cnt == rst_edge);
      check("busy", busy, edge_cnt < next_arb - 1);
      check("ack0", ack0, txn_act && edge_cnt == ack_edge && txn_port == 0);
      check("ack1", ack1, txn_act && edge_cnt == ack_edge && txn_port == 1);
      check("rdata", rdata, exp_rdata);
      if (mem_rd || mem_wr) begin
        check("addr_range", mem_addr < DEPTH, 1);
        if (mem_wr) wr_log.push_back({mem_addr, mem_wdata});
        if (exp_q.size() == 0) check("strobe_extra", {mem_rd, mem_wr}, 0);
        else check("strobe", {mem_wr, mem_addr, mem_wr ? mem_wdata : 8'h00}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  bit hold0 = 0, hold1 = 0;
  int ack_port_log [$];
  int ack_time_log [$];

  task automatic step();
    @(negedge clk);
    #1;
    if (ack0) begin
      ack_port_log.push_back(0); ack_time_log.push_back(edge_cnt);
      if (!hold0) req0 = 1'b0;
    end
    if (ack1) begin
      ack_port_log.push_back(1); ack_time_log.push_back(edge_cnt);
      if (!hold1) req1 = 1'b0;
    end
  endtask

  task automatic issue(input int port, input logic w, input logic [WIDX_W-1:0] wi, input logic [31:0] wd);
    if (port == 0) begin we0 = w; widx0 = wi; wdata0 = wd; req0 = 1'b1; end
    else begin we1 = w; widx1 = wi; wdata1 = wd; req1 = 1'b1; end
  endtask

  task automatic wait_quiet(input int budget);
    for (int i = 0; i < budget && (req0 || req1); i++) step();
    check("timeout", {req0, req1}, 0);
  endtask

  task automatic wait_acks(input int n, input int budget);
    for (int i = 0; i < budget && ack_port_log.size() < n; i++) step();
    check("ack_count", ack_port_log.size(), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; hold0 = 0; hold1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] beef_bytes [4];
    beef_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // reset values while held
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_rst", mem_rst, 1);
    check("rst_busy", busy, 1);
    check("rst_strobes", {mem_rd, mem_wr}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("clear_pulse", mem_rst, 1);
    step();
    check("clear_done", {mem_rst, busy}, 0);

    // cleared word read by port 1
    issue(1, 1'b0, 3'd5, 32'h0);
    wait_quiet(30);
    check("rd_w5", rdata, 32'h0);

    // write then read back through the other port
    wr_log.delete();
    issue(1, 1'b1, 3'd2, 32'hDEADBEEF);
    wait_quiet(30);
    check("wr_w2_bytes", wr_log.size(), 4);
    for (int b = 0; b < 4 && b < wr_log.size(); b++)
      check("wr_w2_byte", wr_log[b], {32'(8 + b), beef_bytes[b]});
    issue(0, 1'b0, 3'd2, 32'h0);
    wait_quiet(30);
    check("rd_w2", rdata, 32'hDEADBEEF);

    // simultaneous requests after reset, then alternation while both hold
    do_reset();
    ack_port_log.delete(); ack_time_log.delete();
    hold0 = 1; hold1 = 1;
    step();
    issue(0, 1'b0, 3'd1, 32'h0);
    issue(1, 1'b0, 3'd3, 32'h0);
    wait_acks(4, 60);
    hold0 = 0; hold1 = 0;
    wait_quiet(40);
    for (int i = 0; i < 4 && i < ack_port_log.size(); i++) check("rr_order", ack_port_log[i], i % 2);
    if (ack_time_log.size() >= 2) check("rr_spacing", ack_time_log[1] - ack_time_log[0], 7);

    // lone port holding req: one ack per 7 cycles
    ack_port_log.delete(); ack_time_log.delete();
    hold0 = 1;
    issue(0, 1'b0, 3'd6, 32'h0);
    wait_acks(4, 60);
    hold0 = 0;
    wait_quiet(40);
    for (int i = 1; i < 4 && i < ack_time_log.size(); i++)
      check("solo_period", ack_time_log[i] - ack_time_log[i - 1], 7);

    // top word: addresses 28..31
    wr_log.delete();
    issue(1, 1'b1, 3'd7, 32'h01020304);
    wait_quiet(30);
    check("wr_w7_last_addr", wr_log.size() == 4 ? wr_log[3][39:8] : 32'hFFFF_FFFF, 31);
    issue(0, 1'b0, 3'd7, 32'h0);
    wait_quiet(30);
    check("rd_w7", rdata, 32'h01020304);

    // reset during byte 2 of a write aborts it and re-clears the RAM
    issue(0, 1'b1, 3'd4, 32'hCAFEF00D);
    for (int i = 0; i < 20 && !(txn_act && edge_cnt == ack_edge - 3); i++) step();
    check("abort_sync", edge_cnt, ack_edge - 3);
    ack_port_log.delete();
    do_reset();
    repeat (3) step();
    check("abort_no_ack", ack_port_log.size(), 0);
    issue(1, 1'b0, 3'd4, 32'h0);
    wait_quiet(30);
    check("rd_w4_cleared", rdata, 32'h0);

    // randomized traffic from both ports
    for (int i = 0; i < 500; i++) begin
      if (!req0 && $urandom_range(2) == 0)
        issue(0, 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom);
      if (!req1 && $urandom_range(2) == 0)
        issue(1, 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom);
      step();
    end
    wait_quiet(40);
    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
